data_cache: RTL

Direct-mapped, write-through, no-write-allocate data cache between the single-cycle MIPS core's data port and the multi-cycle backing data memory. Read hits return data in the same cycle. Misses and all stores stall the core while a req/ack transaction runs on the memory side. Word-granular only: one 32-bit word per line, with no byte enables.

---
 rtl/data_cache_pkg.sv | 31 +++
 rtl/cache_line_store.sv | 58 +++++
 rtl/data_cache.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/data_cache_pkg.sv
// Shared types and helpers for the data cache.
// Holds the FSM state constants, the big-endian byte-array word type used on
// the core and memory ports, and conversions between that type and a flat word.
package data_cache_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned STATE_W = 2;

    // FSM state encoding
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_FILL  = 2'd1;
    localparam logic [STATE_W-1:0] ST_WRITE = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

    // Byte [0] is the most significant byte of the word
    typedef logic [0:3][7:0] word_bytes_t;

    function automatic logic [WORD_W-1:0] pack_word(input word_bytes_t b);
        return {b[0], b[1], b[2], b[3]};
    endfunction

    function automatic word_bytes_t unpack_word(input logic [WORD_W-1:0] w);
        word_bytes_t b;
        b[0] = w[31:24];
        b[1] = w[23:16];
        b[2] = w[15:8];
        b[3] = w[7:0];
        return b;
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays for a direct-mapped cache.
// Ports:
//   clk, rst_b        clock, async active-low reset (clears valid bits only)
//   rd_idx            asynchronous read index
//   rd_valid/tag/data line contents at rd_idx
//   wr_en             synchronous write strobe
//   wr_idx/tag/data   write target and payload
//   wr_set_valid      mark the line valid on this write
//   wr_data_only      update data only; tag and valid untouched
module cache_line_store
    import data_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned TAG_W     = 27
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [WORD_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_set_valid,
    input  logic              wr_data_only
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [WORD_W-1:0]    data_q [NUM_LINES];

    // Valid bits: the only reset state in the arrays
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_q <= '0;
        end else if (wr_en && wr_set_valid && !wr_data_only) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays, no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_idx] <= wr_data;
            if (!wr_data_only) begin
                tag_q[wr_idx] <= wr_tag;
            end
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Ports:
//   clk, rst_b                    clock, async active-low reset
//   halted                        core halted; blocks new transactions
//   cpu_addr/rd_en/wr_en/wdata    core data-port request (held while stalled)
//   cpu_rdata                     load data (valid on a load hit in IDLE)
//   cpu_stall                     combinational stall to the core
//   mem_req/we/addr/wdata         registered backing-memory request
//   mem_rdata, mem_ack            backing-memory response
module data_cache
    import data_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned IDX_W     = $clog2(NUM_LINES)
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            halted,
    input  logic [31:0]     cpu_addr,
    input  logic            cpu_rd_en,
    input  logic            cpu_wr_en,
    input  logic [0:3][7:0] cpu_wdata,
    output logic [0:3][7:0] cpu_rdata,
    output logic            cpu_stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [0:3][7:0] mem_wdata,
    input  logic [0:3][7:0] mem_rdata,
    input  logic            mem_ack
);

    localparam int unsigned TAG_W = WORD_W - IDX_W - 2;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [WORD_W-1:0]  line_data;
    logic               hit;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               ls_wr_en;
    logic               ls_set_valid;
    logic               ls_data_only;
    logic [WORD_W-1:0]  ls_wr_data;

    // Byte offset is meaningless for a word-granular cache
    logic               unused_addr_lsbs;
    assign unused_addr_lsbs = ^cpu_addr[1:0];

    assign idx = cpu_addr[IDX_W+1:2];
    assign tag = cpu_addr[31:IDX_W+2];
    assign hit = line_valid && (line_tag == tag);

    cache_line_store #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_store (
        .clk          (clk),
        .rst_b        (rst_b),
        .rd_idx       (idx),
        .rd_valid     (line_valid),
        .rd_tag       (line_tag),
        .rd_data      (line_data),
        .wr_en        (ls_wr_en),
        .wr_idx       (idx),
        .wr_tag       (tag),
        .wr_data      (ls_wr_data),
        .wr_set_valid (ls_set_valid),
        .wr_data_only (ls_data_only)
    );

    // Line data is always presented; it is meaningful only on a load hit
    assign cpu_rdata = unpack_word(line_data);

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, stall and line-store write control
    always_comb begin
        state_d      = state_q;
        cpu_stall    = 1'b0;
        ls_wr_en     = 1'b0;
        ls_set_valid = 1'b0;
        ls_data_only = 1'b0;
        ls_wr_data   = pack_word(mem_rdata);
        case (state_q)
            ST_IDLE: begin
                if (!halted) begin
                    // Store takes priority over a simultaneous load
                    if (cpu_wr_en) begin
                        cpu_stall = 1'b1;
                        state_d   = ST_WRITE;
                    end else if (cpu_rd_en && !hit) begin
                        cpu_stall = 1'b1;
                        state_d   = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                cpu_stall = 1'b1;
                if (mem_ack) begin
                    ls_wr_en     = 1'b1;
                    ls_set_valid = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_WRITE: begin
                cpu_stall = 1'b1;
                if (mem_ack) begin
                    // Write-through: refresh the line only if already resident
                    ls_wr_en     = hit;
                    ls_data_only = 1'b1;
                    ls_wr_data   = pack_word(cpu_wdata);
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory-side request registers; address/data captured when leaving IDLE
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req <= (state_d == ST_FILL) || (state_d == ST_WRITE);
            mem_we  <= (state_d == ST_WRITE);
            if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) begin
                mem_addr  <= {cpu_addr[31:2], 2'b00};
                mem_wdata <= cpu_wdata;
            end
        end
    end

endmodule
